// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths, special register numbers
// and the register-file clear/ready state encoding.
package mips_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

   typedef enum logic {
      RF_CLEAR,
      RF_READY
   } rf_state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: walks clr_idx over every entry, one per clock.
// Ports: clk, reset_n (sync, active-low) in; busy, clr_we, clr_addr out.
module rf_clear_seq #(
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);
   import mips_pkg::*;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

   rf_state_t         state;
   rf_state_t         state_nxt;
   logic [ADDR_W-1:0] clr_idx;
   logic [ADDR_W-1:0] clr_idx_nxt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= RF_CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      unique case (state)
         RF_CLEAR: begin
            // Wrap back to 0 after LAST is harmless; idx is idle in READY.
            clr_idx_nxt = clr_idx + 1'b1;
            if (clr_idx == LAST) state_nxt = RF_READY;
         end
         RF_READY: state_nxt = RF_READY;
         default:  state_nxt = RF_CLEAR;
      endcase
   end

   assign busy     = (state == RF_CLEAR);
   // A reset edge must leave the array untouched.
   assign clr_we   = busy && reset_n;
   assign clr_addr = clr_idx;

endmodule

// File: rtl/mips_register_file.sv
// 32 x 32 MIPS GPR file: two async read ports, one sync write port, $0 = 0.
// Ports: clk, reset_n, read_reg1/2, write_reg, write_data, reg_write in;
//        read_data1/2, busy out. Macro REGFILE_BYPASS_EN adds WB->ID bypass.
module mips_register_file #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic              reg_write,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic              busy
);
   import mips_pkg::*;

   if (NUM_REGS != 2**ADDR_W) begin : g_bad_cfg
      $error("NUM_REGS must equal 2**ADDR_W");
   end

   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] mem [NUM_REGS];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              ready;
   logic              usr_we;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;

   rf_clear_seq #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_clr (
      .clk      (clk),
      .reset_n  (reset_n),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign ready  = !busy && reset_n;
   assign usr_we = ready && reg_write && (write_reg != ZERO);

   // Clear walk owns the single write port while busy.
   assign we    = clr_we || usr_we;
   assign waddr = clr_we ? clr_addr : write_reg;
   assign wdata = clr_we ? '0 : write_data;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_comb begin
      read_data1 = '0;
      if (!ready || read_reg1 == ZERO) begin
         read_data1 = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (usr_we && read_reg1 == write_reg) begin
         read_data1 = write_data;
`endif
      end else begin
         read_data1 = mem[read_reg1];
      end
   end

   always_comb begin
      read_data2 = '0;
      if (!ready || read_reg2 == ZERO) begin
         read_data2 = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (usr_we && read_reg2 == write_reg) begin
         read_data2 = write_data;
`endif
      end else begin
         read_data2 = mem[read_reg2];
      end
   end

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: expected reads queued at drive
// time, popped and compared on the falling edge.
module tb_mips_register_file;

   logic        clk;
   logic        reset_n;
   logic [4:0]  read_reg1;
   logic [4:0]  read_reg2;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        reg_write;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic        busy;

   mips_register_file dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .write_reg  (write_reg),
      .write_data (write_data),
      .reg_write  (reg_write),
      .read_data1 (read_data1),
      .read_data2 (read_data2),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          port;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [32];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input int port,
                       input logic [31:0] exp);
      exp_t e;
      e.tag  = tag;
      e.port = port;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, (e.port == 1) ? read_data1 : read_data2, e.exp);
      end
   endtask

   task automatic rd(input string tag, input logic [4:0] a1,
                     input logic [4:0] a2);
      read_reg1 = a1;
      read_reg2 = a2;
      push(tag, 1, model[a1]);
      push(tag, 2, model[a2]);
      drain();
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      write_reg  = a;
      write_data = d;
      reg_write  = 1'b1;
      tick();
      reg_write  = 1'b0;
      if (a != 5'd0) model[a] = d;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   // Edges after reset release until busy drops.
   task automatic count_busy(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (busy && n < 100);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      check("ready_timeout", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [4:0]  a;
      logic [31:0] d;
      logic [31:0] haz_exp;

      reset_n    = 1'b0;
      reg_write  = 1'b0;
      read_reg1  = 5'd8;
      read_reg2  = 5'd31;
      write_reg  = '0;
      write_data = '0;
      clear_model();

      repeat (2) tick();
      check("busy_rst", {31'd0, busy}, 32'd1);
      push("rd_in_rst", 1, 32'd0);
      push("rd_in_rst", 2, 32'd0);
      drain();

      @(posedge clk);
      #1;
      reset_n = 1'b1;
      count_busy(n);
      check("busy_len", n, 32);

      for (int i = 0; i < 32; i++)
         rd("clr_all", 5'(i), 5'(31 - i));

      do_write(5'd8, 32'hDEADBEEF);
      do_write(5'd31, 32'h00400010);
      read_reg1 = 5'd8;
      read_reg2 = 5'd31;
      push("wr_r8", 1, 32'hDEADBEEF);
      push("wr_r31", 2, 32'h00400010);
      drain();

      read_reg1  = 5'd0;
      read_reg2  = 5'd0;
      write_reg  = 5'd0;
      write_data = 32'hFFFFFFFF;
      reg_write  = 1'b1;
      push("r0_during", 1, 32'd0);
      push("r0_during", 2, 32'd0);
      drain();
      tick();
      reg_write = 1'b0;
      push("r0_after", 1, 32'd0);
      push("r0_after", 2, 32'd0);
      drain();

      do_write(5'd5, 32'h11);
`ifdef REGFILE_BYPASS_EN
      haz_exp = 32'h22;
`else
      haz_exp = 32'h11;
`endif
      read_reg1  = 5'd5;
      read_reg2  = 5'd5;
      write_reg  = 5'd5;
      write_data = 32'h22;
      reg_write  = 1'b1;
      push("haz_same", 1, haz_exp);
      push("haz_same", 2, haz_exp);
      drain();
      tick();
      reg_write = 1'b0;
      model[5]  = 32'h22;
      push("haz_next", 1, 32'h22);
      drain();

      for (int i = 0; i < 16; i++) begin
         a = 5'($urandom_range(1, 31));
         d = $urandom;
         do_write(a, d);
         rd("rand", a, 5'($urandom_range(0, 31)));
      end

      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (2) tick();
      write_reg  = 5'd9;
      write_data = 32'hABCD;
      reg_write  = 1'b1;
      tick();
      reg_write = 1'b0;
      check("busy_wr_clr", {31'd0, busy}, 32'd1);
      wait_ready();
      clear_model();
      rd("wr_in_clr", 5'd9, 5'd9);

      do_write(5'd3, 32'h3333);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (20) tick();
      read_reg1 = 5'd3;
      push("rd_mid_clr", 1, 32'd0);
      drain();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      tick();
      check("busy_reclr", {31'd0, busy}, 32'd1);
      reset_n = 1'b1;
      count_busy(n);
      check("busy_len2", n, 32);
      clear_model();
      rd("after_reclr", 5'd3, 5'd3);

      do_write(5'd12, 32'h1234);
      rd("r12_load", 5'd12, 5'd12);
      reset_n   = 1'b0;
      read_reg1 = 5'd12;
      read_reg2 = 5'd12;
      push("rd_rst_rdy", 1, 32'd0);
      push("rd_rst_rdy", 2, 32'd0);
      drain();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("busy_rst_rdy", {31'd0, busy}, 32'd1);
      wait_ready();
      clear_model();
      rd("r12_cleared", 5'd12, 5'd12);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Two asynchronous read ports and one synchronous write port.
- Sits directly downstream of the 5-bit write-register select mux (rt / rd / $31 / spare). The mux output drives write_reg.
- After reset, an internal sequencer clears the array one entry per cycle and holds busy high until done. The array therefore needs no per-entry reset fan-out.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of entries; must equal 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- read_reg1  input  ADDR_W  read port 1 address (rs).
- read_reg2  input  ADDR_W  read port 2 address (rt).
- write_reg  input  ADDR_W  write address, from the write-register select mux.
- write_data  input  DATA_W  write data (WB stage).
- reg_write  input  1  write enable.
- read_data1  output  DATA_W  port 1 data, combinational.
- read_data2  output  DATA_W  port 2 data, combinational.
- busy  output  1  high while the clear sequence runs.

Behaviour:
- One clock, clk. Reset is synchronous and active-low on reset_n, sampled only on the rising edge of clk.
- State machine has two states, CLEAR and READY, plus a counter clr_idx of width ADDR_W.
- Reset: on any edge with reset_n=0, state<=CLEAR, clr_idx<=0, busy<=1. Array contents are not touched on that edge.
- CLEAR state, each edge with reset_n=1:
  - mem[clr_idx]<=0 and clr_idx<=clr_idx+1.
  - When clr_idx==NUM_REGS-1, that edge writes the final entry, then state<=READY and busy<=0.
  - busy is therefore high for exactly 32 edges after reset release.
  - clr_idx wrap from 31 to 0 is harmless; it is unused in READY.
- CLEAR state, other rules:
  - reg_write is ignored.
  - read_data1 and read_data2 are forced to 0.
- READY state:
  - On an edge with reg_write=1 and write_reg!=0, mem[write_reg]<=write_data.
  - A write to register 0 is discarded.
- Reads in READY: read_dataN = 0 if read_regN==0, else mem[read_regN]. No clock latency.
- Same-edge read/write (without bypass): the read returns the old value during the write cycle and the new value after the edge.
- Reset mid-clear: the sequence restarts at index 0. busy stays high, with no glitch to 0.
- Reset while READY: busy rises on the same edge and all reads return 0 until the clear completes.
- Reset values: busy=1. read_data1 and read_data2 are 0 while reset_n=0 or busy=1.
- Both read ports may address the same register; each returns the same value.
- Widths: no arithmetic on data. clr_idx increments modulo 2**ADDR_W.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read bypass. If state==READY, reg_write=1, write_reg!=0 and read_regN==write_reg, then read_dataN=write_data in the same cycle. This covers the WB-to-ID hazard in the same cycle.
- Undefined: no bypass. Reads return the stored value, as in Behaviour.
- Register 0 and busy forcing take priority over bypass in both builds.

Decomposition:
- Shared package mips_pkg holds:
  - constants DATA_W=32, REG_ADDR_W=5, NUM_REGS=32, REG_ZERO=5'd0, REG_RA=5'd31;
  - enum rf_state_t {RF_CLEAR, RF_READY}.
- Natural sub-module: rf_clear_seq. It owns the state machine, clr_idx, busy, and the clear write enable/address.
- mips_register_file holds the array, the write-port mux (clear vs. normal) and the read logic.

Test Plan:
- Clear sequence: hold reset_n=0 for 2 cycles, then release. Require busy=1 for exactly 32 edges, then 0. After that, reading all 32 registers returns 0x00000000.
- Basic write/read: write reg 8=0xDEADBEEF and reg 31=0x0040_0010. Require read_reg1=8 -> 0xDEADBEEF and read_reg2=31 -> 0x00400010 on the cycle after the write.
- Register 0: write reg 0=0xFFFFFFFF. Require a read of reg 0 -> 0 on both ports, both during and after the write.
- Same-cycle hazard: reg 5 holds 0x11, then write reg 5=0x22 while read_reg1=5.
  - Without REGFILE_BYPASS_EN: 0x11 in that cycle, 0x22 next cycle.
  - With it: 0x22 in that cycle.
- Write during clear: release reset, then on cycle 3 assert reg_write to reg 9=0xABCD. Require reg 9 reads 0 once busy falls.
- Reset mid-clear and mid-operation:
  - Pulse reset_n low at clear cycle 20. Require busy to stay high for 32 edges after the second release.
  - Load reg 12=0x1234, then reset while READY. Require reg 12 reads 0 after the clear.
